// File: rtl/vector_sweep_ctrl.sv
// Sweeps a DUT through every input vector 0..2^N_IN-1, holds each one for SETTLE
// cycles, then streams the (vector, response) record over a valid/ready handshake.
module vector_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [N_IN-1:0]  rec_vec,
  output logic [N_OUT-1:0] rec_out,
  output logic [N_IN:0]    ones_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0]      SETTLE_RELOAD = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC      = {N_IN{1'b1}};

  state_t           state_r, state_s;
  logic [N_IN-1:0]  vec_r, vec_s;
  logic [7:0]       settle_cnt_r, settle_cnt_s;
  logic             rec_valid_r, rec_valid_s;
  logic [N_IN-1:0]  rec_vec_r, rec_vec_s;
  logic [N_OUT-1:0] rec_out_r, rec_out_s;
  logic [N_IN:0]    ones_count_r, ones_count_s;
  logic             handshake_s;

  assign handshake_s = rec_valid_r & rec_ready;

  // Next-state and next-register values; abort overrides every non-idle state.
  always_comb begin
    state_s      = state_r;
    vec_s        = vec_r;
    settle_cnt_s = settle_cnt_r;
    rec_valid_s  = rec_valid_r;
    rec_vec_s    = rec_vec_r;
    rec_out_s    = rec_out_r;
    ones_count_s = ones_count_r;
    if (abort && (state_r != ST_IDLE)) begin
      state_s     = ST_IDLE;
      rec_valid_s = 1'b0;
      vec_s       = {N_IN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s      = ST_SETTLE;
            vec_s        = {N_IN{1'b0}};
            settle_cnt_s = SETTLE_RELOAD;
            ones_count_s = {(N_IN+1){1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r != 8'd0) begin
            settle_cnt_s = settle_cnt_r - 8'd1;
          end else begin
            state_s      = ST_EMIT;
            rec_out_s    = dut_out;
            rec_vec_s    = vec_r;
            rec_valid_s  = 1'b1;
            ones_count_s = ones_count_r + (N_IN+1)'(dut_out[0]);
          end
        end
        ST_EMIT: begin
          if (handshake_s) begin
            rec_valid_s = 1'b0;
            if (vec_r == LAST_VEC) begin
              state_s = ST_DONE;
            end else begin
              state_s      = ST_SETTLE;
              vec_s        = vec_r + N_IN'(1'b1);
              settle_cnt_s = SETTLE_RELOAD;
            end
          end else begin
            state_s = ST_EMIT;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s     = ST_IDLE;
          rec_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      vec_r        <= {N_IN{1'b0}};
      settle_cnt_r <= 8'd0;
      rec_valid_r  <= 1'b0;
      rec_vec_r    <= {N_IN{1'b0}};
      rec_out_r    <= {N_OUT{1'b0}};
      ones_count_r <= {(N_IN+1){1'b0}};
    end else begin
      state_r      <= state_s;
      vec_r        <= vec_s;
      settle_cnt_r <= settle_cnt_s;
      rec_valid_r  <= rec_valid_s;
      rec_vec_r    <= rec_vec_s;
      rec_out_r    <= rec_out_s;
      ones_count_r <= ones_count_s;
    end
  end

  // The DUT sees the sweep vector directly, so dut_in cannot move during EMIT.
  assign dut_in     = vec_r;
  assign rec_valid  = rec_valid_r;
  assign rec_vec    = rec_vec_r;
  assign rec_out    = rec_out_r;
  assign ones_count = ones_count_r;
  assign busy       = (state_r != ST_IDLE);
  assign done       = (state_r == ST_DONE);

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Bench for vector_sweep_ctrl: a table of sweep scenarios, hand-written corner
// sequences and randomized sweeps checked against a record-list reference model.
module tb_vector_sweep_ctrl;

  logic       CK;
  logic       reset;
  logic       start, abort, rec_ready;
  logic [3:0] dut_in_a, rec_vec_a;
  logic [0:0] dut_out_a, rec_out_a;
  logic       rec_valid_a, busy_a, done_a;
  logic [4:0] ones_count_a;

  logic       start_b;
  logic [3:0] dut_in_b, rec_vec_b;
  logic [0:0] dut_out_b, rec_out_b;
  logic       rec_valid_b, busy_b, done_b;
  logic [4:0] ones_count_b;

  int          fsel;
  logic [15:0] lut;
  int          n_cmp;
  int          n_fail;

  vector_sweep_ctrl #(.N_IN(4), .N_OUT(1), .SETTLE(1)) u_dut_a (
    .CK(CK), .reset(reset), .start(start), .abort(abort),
    .dut_in(dut_in_a), .dut_out(dut_out_a),
    .rec_valid(rec_valid_a), .rec_ready(rec_ready),
    .rec_vec(rec_vec_a), .rec_out(rec_out_a),
    .ones_count(ones_count_a), .busy(busy_a), .done(done_a)
  );

  vector_sweep_ctrl #(.N_IN(4), .N_OUT(1), .SETTLE(3)) u_dut_b (
    .CK(CK), .reset(reset), .start(start_b), .abort(1'b0),
    .dut_in(dut_in_b), .dut_out(dut_out_b),
    .rec_valid(rec_valid_b), .rec_ready(1'b1),
    .rec_vec(rec_vec_b), .rec_out(rec_out_b),
    .ones_count(ones_count_b), .busy(busy_b), .done(done_b)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Device being swept: gate-level functions selected at run time.
  always_comb begin
    case (fsel)
      0:       dut_out_a = &dut_in_a;
      1:       dut_out_a = ^dut_in_a;
      2:       dut_out_a = |dut_in_a;
      default: dut_out_a = lut[dut_in_a];
    endcase
  end
  assign dut_out_b = ^dut_in_b;

  // Reference: expected response of vector v under the selected function.
  function automatic logic ref_out(input int f, input int v);
    case (f)
      0:       return (v == 15);
      1:       return ($countones(v) % 2) == 1;
      2:       return (v != 0);
      default: return lut[v];
    endcase
  endfunction

  function automatic int ref_ones(input int f);
    int s = 0;
    for (int v = 0; v < 16; v++) s += int'(ref_out(f, v));
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse (or hold) start, follow the sweep on negedges, check every record in order.
  task automatic run_sweep(input int stall_vec, input int stall_len, input bit rnd_ready,
                           input bit hold_start, output int done_n, output int first_valid_n);
    int idx = 0;
    int stall_left = stall_len;
    done_n = -1;
    first_valid_n = -1;
    start = 1'b1;
    rec_ready = 1'b1;
    @(posedge CK);
    for (int n = 0; n < 400 && done_n < 0; n++) begin
      @(negedge CK);
      if (!hold_start) start = 1'b0;
      if (n == 0) begin
        check("start_dut_in", dut_in_a, 0);
        check("start_busy", busy_a, 1);
        check("start_ones_clr", ones_count_a, 0);
      end
      if (rec_valid_a && first_valid_n < 0) first_valid_n = n;
      if (rnd_ready) rec_ready = 1'($urandom_range(0, 1));
      else if (rec_valid_a && int'(rec_vec_a) == stall_vec && stall_left > 0) begin
        rec_ready = 1'b0;
        stall_left--;
      end else rec_ready = 1'b1;
      if (rec_valid_a) begin
        if (idx > 15) check("extra_record", 1, 0);
        else begin
          check("rec_vec", rec_vec_a, idx);
          check("rec_out", rec_out_a, ref_out(fsel, idx));
          check("dut_in_held", dut_in_a, idx);
        end
        if (rec_ready) idx++;
      end
      if (done_a) done_n = n;
    end
    rec_ready = 1'b1;
    if (done_n < 0) check("sweep_timeout", 0, 1);
    check("record_count", idx, 16);
  endtask

  typedef struct {
    int fsel;
    int stall_vec;
    int stall_len;
    int exp_ones;
    int exp_done;
  } row_t;

  row_t tbl[6];

  initial begin
    int dn, fv, exp_o, last_n, idx, found, seen;
    n_cmp = 0; n_fail = 0;
    fsel = 0; lut = 16'h0000;
    start = 1'b0; start_b = 1'b0; abort = 1'b0; rec_ready = 1'b1;

    tbl[0] = '{0, -1, 0, 1, 32};
    tbl[1] = '{0,  3, 5, 1, 37};
    tbl[2] = '{1, -1, 0, 8, 32};
    tbl[3] = '{2, -1, 0, 15, 32};
    tbl[4] = '{0, 15, 2, 1, 34};
    tbl[5] = '{1,  0, 3, 8, 35};

    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_dut_in", dut_in_a, 0);
    check("rst_rec_valid", rec_valid_a, 0);
    check("rst_rec_vec", rec_vec_a, 0);
    check("rst_rec_out", rec_out_a, 0);
    check("rst_ones", ones_count_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    repeat (2) @(negedge CK);
    reset = 1'b1;
    repeat (2) @(negedge CK);
    check("idle_after_rst", busy_a, 0);

    for (int r = 0; r < 6; r++) begin
      fsel = tbl[r].fsel;
      run_sweep(tbl[r].stall_vec, tbl[r].stall_len, 1'b0, 1'b0, dn, fv);
      check("done_cycle", dn, tbl[r].exp_done);
      check("first_valid", fv, 1);
      check("ones_final", ones_count_a, tbl[r].exp_ones);
      @(negedge CK);
      check("done_one_cycle", done_a, 0);
      check("busy_after_done", busy_a, 0);
      check("ones_held", ones_count_a, tbl[r].exp_ones);
    end

    // SETTLE=3 instance sweeping a 4-input XOR.
    start_b = 1'b1;
    @(posedge CK);
    idx = 0; last_n = 0; dn = -1;
    for (int n = 0; n < 200 && dn < 0; n++) begin
      @(negedge CK);
      start_b = 1'b0;
      if (rec_valid_b) begin
        check("b_rec_vec", rec_vec_b, idx);
        check("b_parity", rec_out_b, $countones(idx) % 2);
        if (idx == 0) check("b_first_valid", n, 3);
        else check("b_spacing", n - last_n, 4);
        last_n = n;
        idx++;
      end
      if (done_b) dn = n;
    end
    check("b_records", idx, 16);
    check("b_done_cycle", dn, 64);
    check("b_ones", ones_count_b, 8);

    // Abort while stalled in EMIT at vector 7.
    fsel = 1;
    start = 1'b1;
    @(posedge CK);
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge CK);
      start = 1'b0;
      if (rec_valid_a && rec_vec_a == 4'd7) begin
        rec_ready = 1'b0;
        found = 1;
      end else rec_ready = 1'b1;
    end
    check("abort_reached", found, 1);
    abort = 1'b1;
    @(negedge CK);
    abort = 1'b0;
    rec_ready = 1'b1;
    check("abort_busy", busy_a, 0);
    check("abort_valid", rec_valid_a, 0);
    check("abort_dut_in", dut_in_a, 0);
    check("abort_partial_ones", ones_count_a, 4);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (done_a) seen = 1;
      @(negedge CK);
    end
    check("abort_no_done", seen, 0);
    check("abort_idle_ones", ones_count_a, 4);
    run_sweep(-1, 0, 1'b0, 1'b0, dn, fv);
    check("restart_done", dn, 32);
    check("restart_ones", ones_count_a, 8);
    @(negedge CK);

    // abort in IDLE together with start: start wins, then abort a live sweep.
    start = 1'b1; abort = 1'b1;
    @(negedge CK);
    start = 1'b0; abort = 1'b0;
    check("start_beats_abort", busy_a, 1);
    check("start_beats_abort_vec", dut_in_a, 0);
    @(negedge CK);
    abort = 1'b1;
    @(negedge CK);
    abort = 1'b0;
    check("abort_settle_busy", busy_a, 0);

    // Asynchronous reset mid-SETTLE at vector 9.
    fsel = 0;
    start = 1'b1;
    @(posedge CK);
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge CK);
      start = 1'b0;
      if (busy_a && !rec_valid_a && dut_in_a == 4'd9) found = 1;
    end
    check("reset_reached", found, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_dut_in", dut_in_a, 0);
    check("arst_valid", rec_valid_a, 0);
    check("arst_rec_vec", rec_vec_a, 0);
    check("arst_rec_out", rec_out_a, 0);
    check("arst_ones", ones_count_a, 0);
    check("arst_busy", busy_a, 0);
    @(negedge CK);
    reset = 1'b1;
    repeat (3) @(negedge CK);
    check("post_rst_idle", busy_a, 0);
    check("post_rst_dut_in", dut_in_a, 0);

    // start held high through two sweeps.
    fsel = 0;
    run_sweep(-1, 0, 1'b0, 1'b1, dn, fv);
    check("hold_done1", dn, 32);
    @(negedge CK);
    check("hold_idle_gap", busy_a, 0);
    run_sweep(-1, 0, 1'b0, 1'b1, dn, fv);
    start = 1'b0;
    check("hold_done2", dn, 32);
    check("hold_ones2", ones_count_a, 1);
    @(negedge CK);

    // Random response tables with random back-pressure.
    for (int it = 0; it < 4; it++) begin
      lut = 16'($urandom);
      fsel = 3;
      exp_o = ref_ones(3);
      run_sweep(-1, 0, 1'b1, 1'b0, dn, fv);
      check("rnd_ones", ones_count_a, exp_o);
      check("rnd_done_late_enough", dn >= 32, 1);
      @(negedge CK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
